seg7_capture_rx: RTL

Receive-side companion to the team's 7448 BCD-to-seven-segment decoder. Samples the active-high segment bus `{a,b,c,d,e,f,g}` and synchronises it. Requires each pattern to hold for a programmable number of cycles, then decodes it back to a 4-bit BCD code with blank and invalid flags. Each decoded record goes out through a one-entry valid/ready holding register. Used in loopback self-test of the display path and for reading back external 7448-driven displays.

---
 rtl/seg7_rx_if.sv | 12 +
 rtl/seg7_capture_rx.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/seg7_rx_if.sv
// Output handshake of seg7_capture_rx: one decoded record per valid/ready transfer.
// The receiver drives the master side and the consumer drives the slave side.
interface seg7_rx_if;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bcd;
  logic       out_blank;
  logic       out_err;

  modport master (output out_valid, out_bcd, out_blank, out_err, input out_ready);
  modport slave  (input out_valid, out_bcd, out_blank, out_err, output out_ready);
endinterface

// File: rtl/seg7_capture_rx.sv
// Seven-segment bus receiver: synchronise, debounce, decode a 7448 glyph and hold one record.
// Optional macro SEG7_RX_CHANGE_ONLY_EN: push only patterns that differ from the last accepted one.
module seg7_capture_rx #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] seg_in,
  input  logic       ovf_clr,
  output logic       ovf,
  seg7_rx_if.master  bus
);

  typedef enum logic {TRACK, LOCKED} state_t;

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0] s1, s2, s2_prev;
  logic [7:0] run_q, run_next;
  state_t     state_q, state_next;
  logic       accept, push, pop;
  logic [3:0] dec_bcd;
  logic       dec_blank, dec_err;
  logic [3:0] bcd_q;
  logic       valid_q, blank_q, err_q;

  // s2_prev is the previous s2, so the stability count starts one edge after s2 changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 7'h00;
      s2      <= 7'h00;
      s2_prev <= 7'h00;
      run_q   <= STABLE;
      state_q <= LOCKED;
    end else begin
      // NOTE: sequential state uses <= so every flop updates from the pre-edge values.
      s1      <= seg_in;
      s2      <= s1;
      s2_prev <= s2;
      run_q   <= run_next;
      state_q <= state_next;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    run_next   = 8'd1;
    state_next = state_q;
    accept     = 1'b0;
    if (s2 == s2_prev) begin
      run_next = (run_q == STABLE) ? run_q : run_q + 8'd1;
    end
    // A change with STABLE_CYCLES=1 is accepted on the same edge it is seen.
    if ((run_next == STABLE) && ((state_q == TRACK) || (s2 != s2_prev))) begin
      accept     = 1'b1;
      state_next = LOCKED;
    end else if (s2 != s2_prev) begin
      state_next = TRACK;
    end
  end

  always_comb begin
    dec_bcd   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (s2)
      7'h7E: dec_bcd = 4'h0;
      7'h30: dec_bcd = 4'h1;
      7'h6D: dec_bcd = 4'h2;
      7'h79: dec_bcd = 4'h3;
      7'h33: dec_bcd = 4'h4;
      7'h5B: dec_bcd = 4'h5;
      7'h1F: dec_bcd = 4'h6;
      7'h70: dec_bcd = 4'h7;
      7'h7F: dec_bcd = 4'h8;
      7'h73: dec_bcd = 4'h9;
      7'h0D: dec_bcd = 4'hA;
      7'h19: dec_bcd = 4'hB;
      7'h23: dec_bcd = 4'hC;
      7'h4B: dec_bcd = 4'hD;
      7'h0F: dec_bcd = 4'hE;
      7'h00: begin
        dec_bcd   = 4'hF;
        dec_blank = 1'b1;
      end
      default: dec_err = 1'b1;
    endcase
  end

`ifdef SEG7_RX_CHANGE_ONLY_EN
  logic [6:0] last_q;

  // Tracks every acceptance, including ones whose record is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 7'h00;
    end else if (accept) begin
      last_q <= s2;
    end
  end

  assign push = accept && (s2 != last_q);
`else
  assign push = accept;
`endif

  assign pop = valid_q && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the record fields are reset too, because they are visible outputs with defined reset values.
      valid_q <= 1'b0;
      bcd_q   <= 4'h0;
      blank_q <= 1'b0;
      err_q   <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push && (!valid_q || pop)) begin
        valid_q <= 1'b1;
        bcd_q   <= dec_bcd;
        blank_q <= dec_blank;
        err_q   <= dec_err;
      end else if (pop) begin
        valid_q <= 1'b0;
      end
      // A drop in the same cycle as a clear leaves the flag set.
      if (push && valid_q && !pop) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_bcd   = bcd_q;
  assign bus.out_blank = blank_q;
  assign bus.out_err   = err_q;

endmodule
